// File: rtl/dadda_mul64_seq_if.sv
// dadda_mul64_seq_if: operand/result handshake bundle for dadda_mul64_seq.
//   in_valid/in_ready/a/b   : operand pair channel (a, b unsigned 64-bit)
//   out_valid/out_ready/y   : 128-bit product channel
//   busy                    : block holds an operation (acceptance .. output handshake)
// master = producer/consumer side, slave = multiplier side.
interface dadda_mul64_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  a;
  logic [63:0]  b;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] y;
  logic         busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y, busy
  );
endinterface

// File: rtl/dadda_mul64_seq.sv
// dadda_mul64_seq: sequential 64x64 -> 128 unsigned multiplier around one
// combinational 32x32 core. Each operation feeds the core four partial
// products (lo*lo, lo*hi, hi*lo, hi*hi) on consecutive cycles and
// shift-accumulates them into a 128-bit accumulator that drives y.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : dadda_mul64_seq_if.slave (in_valid/in_ready/a/b,
//          out_valid/out_ready/y, busy)
// Optional feature: define DADDA_MUL64_EARLY_EXIT_EN to finish after a
// single partial product when both operand high halves are zero.

// Combinational 32x32 core; the reduction tree is left to the multiplier
// mapping of the synthesis flow.
module dadda_core32 (
  input  logic [31:0] x,
  input  logic [31:0] z,
  output logic [63:0] p
);
  assign p = {32'd0, x} * {32'd0, z};
endmodule

module dadda_mul64_seq (
  input  logic               clk,
  input  logic               rst,
  dadda_mul64_seq_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t       state, state_nxt;
  logic [1:0]   cnt;
  logic [63:0]  a_q, b_q;
  logic [127:0] acc;
  logic [31:0]  core_a, core_b;
  logic [63:0]  pp;
  logic [127:0] pp_sh;
  logic         accept;
  logic         last_pp;

  // cnt[1] picks the a half, cnt[0] the b half:
  // 0 lo*lo, 1 lo*hi, 2 hi*lo, 3 hi*hi
  assign core_a = cnt[1] ? a_q[63:32] : a_q[31:0];
  assign core_b = cnt[0] ? b_q[63:32] : b_q[31:0];

  dadda_core32 u_core (.x(core_a), .z(core_b), .p(pp));

  always_comb begin
    pp_sh = {64'd0, pp};
    case (cnt)
      2'd0:    pp_sh = {64'd0, pp};
      2'd1,
      2'd2:    pp_sh = {32'd0, pp, 32'd0};
      default: pp_sh = {pp, 64'd0};
    endcase
  end

`ifdef DADDA_MUL64_EARLY_EXIT_EN
  // Both high halves zero: lo*lo is the whole product.
  logic lo_only;
  always_ff @(posedge clk) begin
    if (rst)         lo_only <= 1'b0;
    else if (accept) lo_only <= (bus.a[63:32] == 32'd0) && (bus.b[63:32] == 32'd0);
  end
  assign last_pp = (cnt == 2'd3) || lo_only;
`else
  assign last_pp = (cnt == 2'd3);
`endif

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.y         = acc;

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)        state_nxt = MUL;
      MUL:     if (last_pp)       state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
      acc   <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q <= bus.a;
        b_q <= bus.b;
        acc <= '0;
        cnt <= 2'd0;
      end else if (state == MUL) begin
        // True product < 2^128, so the 128-bit sum never wraps.
        acc <= acc + pp_sh;
        cnt <= cnt + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_dadda_mul64_seq.sv
// tb_dadda_mul64_seq: directed + randomized checks of dadda_mul64_seq
// against 128-bit arithmetic products.
module tb_dadda_mul64_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

`ifdef DADDA_MUL64_EARLY_EXIT_EN
  localparam int SMALL_LAT = 1;
`else
  localparam int SMALL_LAT = 4;
`endif

  dadda_mul64_seq_if bus ();

  dadda_mul64_seq dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [127:0] ref_mul(input logic [63:0] x, input logic [63:0] z);
    logic [127:0] xe, ze;
    xe = {64'd0, x};
    ze = {64'd0, z};
    return xe * ze;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand pair (in_ready assumed high), then counts cycles
  // from the acceptance edge until out_valid (bounded at 20).
  task automatic issue(input logic [63:0] x, input logic [63:0] z, output int lat);
    bus.in_valid = 1'b1;
    bus.a = x;
    bus.b = z;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (bus.in_ready !== 1'b0)  begin failures++; $display("FAIL rst_in_ready got=%0b exp=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0)      begin failures++; $display("FAIL rst_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.y !== 128'd0)       begin failures++; $display("FAIL rst_y got=%h exp=0", bus.y); end
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1)  begin failures++; $display("FAIL post_rst_in_ready got=%0b exp=1", bus.in_ready); end
  endtask

  task automatic test_max();
    int lat;
    bus.out_ready = 1'b1;
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL max_latency got=%0d exp=4", lat); end
    checks++; if (bus.y !== 128'hFFFFFFFF_FFFFFFFE_00000000_00000001)
      begin failures++; $display("FAIL max_y got=%h exp=fffffffffffffffe0000000000000001", bus.y); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL max_valid_one_cycle got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1)  begin failures++; $display("FAIL max_in_ready_after got=%0b exp=1", bus.in_ready); end
  endtask

  task automatic test_halves();
    int lat;
    issue(64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, lat);
    checks++; if (bus.y !== (128'd1 << 64)) begin failures++; $display("FAIL hi_hi_y got=%h exp=2^64", bus.y); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL hi_hi_latency got=%0d exp=4", lat); end
    tick();
    issue(64'd3, 64'd5, lat);
    checks++; if (bus.y !== 128'd15) begin failures++; $display("FAIL small_y got=%0d exp=15", bus.y); end
    checks++; if (lat !== SMALL_LAT) begin failures++; $display("FAIL small_latency got=%0d exp=%0d", lat, SMALL_LAT); end
    tick();
    issue(64'd0, 64'hDEAD_BEEF_0123_4567, lat);
    checks++; if (bus.y !== 128'd0) begin failures++; $display("FAIL zero_y got=%h exp=0", bus.y); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL zero_latency got=%0d exp=4", lat); end
    tick();
  endtask

  task automatic test_stall();
    int lat;
    logic [127:0] exp_y;
    exp_y = 128'h2468ACF1_3579BDE0;
    bus.out_ready = 1'b0;
    issue(64'h1234_5678_9ABC_DEF0, 64'd2, lat);
    checks++; if (bus.y !== exp_y) begin failures++; $display("FAIL stall_y got=%h exp=%h", bus.y, exp_y); end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus.in_valid = 1'b1; bus.a = 64'd99; bus.b = 64'd77;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      checks++;
      if (bus.y !== exp_y || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d y=%h ov=%0b ir=%0b busy=%0b exp y=%h ov=1 ir=0 busy=1",
                 i, bus.y, bus.out_valid, bus.in_ready, bus.busy, exp_y);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      begin failures++; $display("FAIL stall_release ov=%0b ir=%0b exp ov=0 ir=1", bus.out_valid, bus.in_ready); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL stall_ignored_input busy=%0b exp=0", bus.busy); end
  endtask

  task automatic test_mid_reset();
    int lat;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.a = 64'hDEAD_BEEF_CAFE_F00D; bus.b = 64'h1357_9BDF_2468_ACE0;
    tick();                   // acceptance edge
    bus.in_valid = 1'b0;
    tick();                   // first add done; now in second MUL cycle
    rst = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.y !== 128'd0)
      begin failures++; $display("FAIL mid_rst ov=%0b busy=%0b y=%h exp 0/0/0", bus.out_valid, bus.busy, bus.y); end
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_in_ready got=%0b exp=1", bus.in_ready); end
    issue(64'd7, 64'd9, lat);
    checks++; if (bus.y !== 128'd63) begin failures++; $display("FAIL mid_rst_after_y got=%0d exp=63", bus.y); end
    tick();
  endtask

  task automatic test_back_to_back();
    localparam int N = 1000;
    logic [127:0] q[$];
    logic [127:0] exp_y;
    int nin, nout, cyc, mode;
    logic hit;
    nin = 0; nout = 0; cyc = 0;
    bus.in_valid = 1'b1;
    bus.a = {$urandom, $urandom};
    bus.b = {$urandom, $urandom};
    while (nout < N && cyc < 40000) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL b2b_extra_output y=%h", bus.y);
        end else begin
          exp_y = q.pop_front();
          if (bus.y !== exp_y) begin
            failures++; $display("FAIL b2b_y idx=%0d got=%h exp=%h", nout, bus.y, exp_y);
          end
        end
        nout++;
      end
      hit = bus.in_valid && bus.in_ready;
      if (hit) begin
        q.push_back(ref_mul(bus.a, bus.b));
        nin++;
      end
      tick();
      cyc++;
      if (hit || !bus.in_valid) begin
        if (nin < N && $urandom_range(0, 7) != 0) begin
          mode = $urandom_range(0, 3);
          bus.in_valid = 1'b1;
          case (mode)
            0: begin bus.a = {32'd0, $urandom}; bus.b = {32'd0, $urandom}; end
            1: begin bus.a = 64'hFFFF_FFFF_FFFF_FFFF; bus.b = {$urandom, $urandom}; end
            default: begin bus.a = {$urandom, $urandom}; bus.b = {$urandom, $urandom}; end
          endcase
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    checks++; if (nout !== N) begin failures++; $display("FAIL b2b_timeout outputs=%0d exp=%0d", nout, N); end
    checks++; if (nin !== nout) begin failures++; $display("FAIL b2b_count accepted=%0d produced=%0d", nin, nout); end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_max();
    test_halves();
    test_stall();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
